// File: rtl/delay_line_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : delay_line_arbiter_pkg
// Description : Shared constants, the tag record and a clog2 helper for the
//               delay-line arbiter. DL_DEPTH is the delay-line latency
//               (fifosize + 1).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package delay_line_arbiter_pkg;

    localparam int DL_WIDTH    = 12;
    localparam int DL_FIFOSIZE = 10;
    localparam int DL_DEPTH    = DL_FIFOSIZE + 1;
    localparam int DL_NREQ     = 4;
    localparam int DL_MAX_OUT  = 4;

    // Owner ids are sized for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;
    localparam int TAG_W    = 1 + TAG_ID_W;

    typedef struct packed {
        logic                v;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // Ceiling log2, never less than 1 so vectors always have a bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_line_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : delay_line_arbiter_rr_arbiter
// Description : Combinational round-robin pick. Returns the first asserted
//               request found scanning ptr, ptr+1, ... modulo NREQ.
// Ports       : req_i   - request vector
//               ptr_i   - index with highest priority this cycle
//               grant_o - one-hot grant (0 when nothing requested)
//               idx_o   - granted index
//               any_o   - a grant exists
// Revision    : 1.0 - initial release
// ============================================================================
module delay_line_arbiter_rr_arbiter
    import delay_line_arbiter_pkg::*;
#(
    parameter int NREQ = DL_NREQ
) (
    input  logic [NREQ-1:0]     req_i,
    input  logic [TAG_ID_W-1:0] ptr_i,
    output logic [NREQ-1:0]     grant_o,
    output logic [TAG_ID_W-1:0] idx_o,
    output logic                any_o
);

    // Each request gets a rotated distance from ptr; the smallest distance
    // among asserted requests wins.
    always_comb begin
        int p;
        int d;
        int best_d;
        p      = int'(ptr_i);
        d      = 0;
        best_d = NREQ;
        idx_o  = '0;
        any_o  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i >= p) ? (i - p) : (i + NREQ - p);
            if (req_i[i] && (d < best_d)) begin
                best_d = d;
                idx_o  = TAG_ID_W'(i);
                any_o  = 1'b1;
            end
        end
    end

    always_comb begin
        grant_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_o[i] = any_o && (idx_o == TAG_ID_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/delay_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : delay_line_arbiter
// Description : Shares one free-running delay line between NREQ requesters.
//               One sample per cycle is picked round-robin and driven onto
//               the line; a parallel tag pipeline of the same depth returns
//               each output sample to its owner.
// Ports       : clk_i       - rising-edge clock (shared with the delay line)
//               reset_i     - synchronous active-high reset
//               req_valid_i - per-requester sample valid
//               req_data_i  - requester i data in [i*WIDTH +: WIDTH]
//               req_ready_o - one-hot accept strobe
//               pipe_din_o  - to delay-line input (0 on bubble)
//               pipe_dout_i - from delay-line output
//               rsp_valid_o - one-hot owner of pipe_dout_i this cycle
//               rsp_data_o  - pipe_dout_i pass-through
//               busy_o      - any sample in flight
// Revision    : 1.0 - initial release
// ============================================================================
module delay_line_arbiter
    import delay_line_arbiter_pkg::*;
#(
    parameter int WIDTH   = DL_WIDTH,
    parameter int DEPTH   = DL_DEPTH,
    parameter int NREQ    = DL_NREQ,
    parameter int MAX_OUT = DL_MAX_OUT
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*WIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic [WIDTH-1:0]      pipe_din_o,
    input  logic [WIDTH-1:0]      pipe_dout_i,
    output logic [NREQ-1:0]       rsp_valid_o,
    output logic [WIDTH-1:0]      rsp_data_o,
    output logic                  busy_o
);

    localparam int CNT_W = clog2(MAX_OUT + 1);

    logic [TAG_ID_W-1:0] ptr_q;
    logic [TAG_ID_W-1:0] ptr_d;
    tag_t                tag_q [DEPTH];
    logic [CNT_W-1:0]    cnt_q [NREQ];
    logic [CNT_W-1:0]    cnt_d [NREQ];

    logic [NREQ-1:0]     w_elig;
    logic [NREQ-1:0]     w_arb_grant;
    logic [TAG_ID_W-1:0] w_arb_idx;
    logic                w_arb_any;
    logic [NREQ-1:0]     w_grant;
    logic                w_gnt_any;
    logic [WIDTH-1:0]    w_din;
    tag_t                w_out_tag;
    logic [NREQ-1:0]     w_rsp_valid;
    logic                w_busy;

    // A requester is only eligible while it has room for another sample.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = req_valid_i[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
        end
    end

    delay_line_arbiter_rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req_i   (w_elig),
        .ptr_i   (ptr_q),
        .grant_o (w_arb_grant),
        .idx_o   (w_arb_idx),
        .any_o   (w_arb_any)
    );

    // No sample is accepted while reset is held.
    assign w_grant   = reset_i ? '0 : w_arb_grant;
    assign w_gnt_any = w_arb_any & ~reset_i;

    always_comb begin
        w_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_din = req_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (w_gnt_any) begin
            if (int'(w_arb_idx) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = w_arb_idx + TAG_ID_W'(1);
            end
        end
    end

    // The last tag stage lines up with pipe_dout_i.
    assign w_out_tag = tag_q[DEPTH-1];

    always_comb begin
        w_rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rsp_valid[i] = w_out_tag.v && (w_out_tag.id == TAG_ID_W'(i));
        end
    end

    // Accept and response in the same cycle cancel out.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (w_grant[i] && !w_rsp_valid[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!w_grant[i] && w_rsp_valid[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_busy = w_busy | (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                tag_q[s] <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            tag_q[0].v  <= w_gnt_any;
            tag_q[0].id <= w_arb_idx;
            for (int s = 1; s < DEPTH; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt_chk
            a_cnt_bound : assert property (@(posedge clk_i) disable iff (reset_i)
                cnt_q[gi] <= CNT_W'(MAX_OUT));
        end
    endgenerate

    assign req_ready_o = w_grant;
    assign pipe_din_o  = w_din;
    assign rsp_valid_o = w_rsp_valid;
    assign rsp_data_o  = pipe_dout_i;
    assign busy_o      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_delay_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_line_arbiter
// Description : Self-checking bench for delay_line_arbiter with a behavioural
//               11-cycle delay line (fifosize 10).
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_line_arbiter;
    import delay_line_arbiter_pkg::*;

    localparam int W = DL_WIDTH;
    localparam int D = DL_DEPTH;
    localparam int N = 4;
    localparam int M = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   pipe_din;
    logic [W-1:0]   pipe_dout;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    delay_line_arbiter #(
        .WIDTH   (W),
        .DEPTH   (D),
        .NREQ    (N),
        .MAX_OUT (M)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .pipe_din_o  (pipe_din),
        .pipe_dout_i (pipe_dout),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .busy_o      (busy)
    );

    // Behavioural delay line, flushed by the same reset.
    logic [W-1:0] dl_q [D];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < D; s++) dl_q[s] <= '0;
        end else begin
            dl_q[0] <= pipe_din;
            for (int s = 1; s < D; s++) dl_q[s] <= dl_q[s-1];
        end
    end
    assign pipe_dout = dl_q[D-1];

    typedef struct {
        logic [N-1:0]   valid;
        logic [N*W-1:0] data;
        logic [N-1:0]   ready;
        logic [W-1:0]   din;
        logic [N-1:0]   rv;
        logic [W-1:0]   rd;
        logic           bz;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [N-1:0] v, input logic [N*W-1:0] dat,
                       input logic [N-1:0] rdy, input logic [W-1:0] din,
                       input logic [N-1:0] rv, input logic [W-1:0] rd,
                       input logic bz);
        vec_t e;
        e.valid = v;  e.data = dat; e.ready = rdy; e.din = din;
        e.rv    = rv; e.rd   = rd;  e.bz    = bz;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [N*W-1:0] dall;
    logic [W-1:0]   dv;
    logic [N-1:0]   er;
    logic [N-1:0]   erv;
    logic [W-1:0]   erd;
    int             idx;

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        dall      = {12'h444, 12'h333, 12'h222, 12'h111};

        // Single req0 sample: bubble gaps, response 11 cycles later.
        add(4'b0001, 48'h000000000ABC, 4'b0001, 12'hABC, 4'b0000, 12'h000, 1'b0);
        repeat (10) add('0, '0, '0, '0, '0, '0, 1'b1);
        add('0, '0, '0, '0, 4'b0001, 12'hABC, 1'b1);
        add('0, '0, '0, '0, '0, '0, 1'b0);

        // All requesters valid; pointer starts at 1 after the req0 grant.
        for (int k = 0; k < 8; k++) begin
            idx = (k + 1) % 4;
            dv  = W'(12'h111 * (idx + 1));
            add(4'hF, dall, N'(1 << idx), dv, '0, '0, (k != 0));
        end
        repeat (3) add('0, '0, '0, '0, '0, '0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            idx = (k + 1) % 4;
            dv  = W'(12'h111 * (idx + 1));
            add('0, '0, '0, '0, N'(1 << idx), dv, 1'b1);
        end
        add('0, '0, '0, '0, '0, '0, 1'b0);

        // req3 on alternate cycles: bubbles interleave with samples.
        for (int k = 0; k < 8; k++) begin
            dv = W'(12'h3A1 + k / 2);
            if (k % 2 == 0) add(4'b1000, {dv, 36'h0}, 4'b1000, dv, '0, '0, (k != 0));
            else            add('0, '0, '0, '0, '0, '0, 1'b1);
        end
        repeat (3) add('0, '0, '0, '0, '0, '0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            dv = W'(12'h3A1 + k / 2);
            if (k % 2 == 0) add('0, '0, '0, '0, 4'b1000, dv, 1'b1);
            else            add('0, '0, '0, '0, '0, '0, (k != 7));
        end

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            req_valid = tbl[i].valid;
            req_data  = tbl[i].data;
            @(negedge clk);
            chk($sformatf("tbl[%0d] req_ready", i), 64'(req_ready), 64'(tbl[i].ready));
            chk($sformatf("tbl[%0d] pipe_din",  i), 64'(pipe_din),  64'(tbl[i].din));
            chk($sformatf("tbl[%0d] rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].rv));
            chk($sformatf("tbl[%0d] rsp_data",  i), 64'(rsp_data),  64'(tbl[i].rd));
            chk($sformatf("tbl[%0d] busy",      i), 64'(busy),      64'(tbl[i].bz));
        end

        // req2 alone saturates at 4 in flight; later cycles see accept and
        // response together, which must leave the count unchanged.
        do_reset();
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            dv        = W'(12'h200 + k);
            req_valid = 4'b0100;
            req_data  = {12'h000, dv, 24'h000000};
            @(negedge clk);
            er  = ((k <= 3) || (k >= 12 && k <= 15) || (k >= 24 && k <= 27)) ? 4'b0100 : 4'b0000;
            erv = ((k >= 11 && k <= 14) || (k >= 23 && k <= 26)) ? 4'b0100 : 4'b0000;
            erd = (erv != 0) ? W'(12'h200 + k - 11) : 12'h000;
            chk($sformatf("sat[%0d] req_ready", k), 64'(req_ready), 64'(er));
            chk($sformatf("sat[%0d] pipe_din",  k), 64'(pipe_din),  64'((er != 0) ? dv : 12'h000));
            chk($sformatf("sat[%0d] rsp_valid", k), 64'(rsp_valid), 64'(erv));
            chk($sformatf("sat[%0d] rsp_data",  k), 64'(rsp_data),  64'(erd));
            chk($sformatf("sat[%0d] busy",      k), 64'(busy),      64'(k != 0));
        end

        // Reset with 5 samples in flight discards them silently.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            req_valid = 4'hF;
            req_data  = dall;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst req_ready", 64'(req_ready), 64'(0));
        chk("rst pipe_din",  64'(pipe_din),  64'(0));
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst[%0d] rsp_valid", k), 64'(rsp_valid), 64'(0));
            chk($sformatf("post_rst[%0d] busy",      k), 64'(busy),      64'(0));
            @(posedge clk);
            #1;
        end
        // Pointer is back at 0, so req0 wins with everyone requesting.
        req_valid = 4'hF;
        req_data  = dall;
        @(negedge clk);
        chk("post_rst ptr req_ready", 64'(req_ready), 64'(4'b0001));
        chk("post_rst ptr pipe_din",  64'(pipe_din),  64'(12'h111));
        @(posedge clk);
        #1;
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
